// File: rtl/vrlp_eth_framer_tbl_pkg.sv
// Shared definitions for the VRLP Ethernet/IPv4/UDP table framer:
// FSM state encoding, settings-bus offsets and fixed protocol constants.
package vrlp_eth_framer_tbl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_HDR4,
    ST_HDR5,
    ST_HDR6,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  // Settings register offsets relative to BASE.
  localparam int unsigned SR_SRC_MAC_HI  = 0;
  localparam int unsigned SR_SRC_MAC_LO  = 1;
  localparam int unsigned SR_SRC_IP      = 2;
  localparam int unsigned SR_SRC_UDP     = 3;
  localparam int unsigned SR_TBL_IDX     = 4;
  localparam int unsigned SR_DST_IP      = 5;
  localparam int unsigned SR_DST_UDP_MAC = 6;
  localparam int unsigned SR_DST_MAC_LO  = 7;
  localparam int unsigned SR_ENTRY_EN    = 8;

  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

  // One RAM read cycle plus two checksum pipeline stages.
  localparam int unsigned LOOKUP_CYCLES  = 3;

  // Folds a 20-bit partial sum of ten 16-bit words twice so every
  // end-around carry is absorbed; the second fold can never carry out.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + 17'(s[19:16]);
    return t[15:0] + 16'(t[16]);
  endfunction

endpackage

// File: rtl/vrlp_eth_framer_tbl_csum.sv
// ip_hdr_checksum_pipe: two-stage IPv4 header checksum over a 160-bit
// header whose checksum field is zero. Stage 1 sums the ten words,
// stage 2 folds the carries and complements.
module ip_hdr_checksum_pipe
  import vrlp_eth_framer_tbl_pkg::*;
(
  input  logic         clk,
  input  logic [159:0] hdr,
  output logic [15:0]  csum
);

  logic [19:0] sum_c;
  logic [19:0] sum_q;

  // Raw 20-bit sum of the ten header words; wide enough to never overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_c = '0;
    for (int i = 0; i < 10; i++) begin
      sum_c = sum_c + 20'(hdr[16*i +: 16]);
    end
  end

  // Pipeline registers: pure datapath, so no reset is needed.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    sum_q <= sum_c;
    csum  <= ~csum_fold(sum_q);
  end

endmodule

// File: rtl/vrlp_eth_framer_tbl.sv
// vrlp_eth_framer_tbl: prepends Ethernet/IPv4/UDP headers to VRLP packets
// using a per-stream destination table; packets whose entry is disabled
// are dropped. Optional macro VRLP_FRAMER_IDENT_EN enables a running IPv4
// identification counter (otherwise ident is fixed at zero).
module vrlp_eth_framer_tbl
  import vrlp_eth_framer_tbl_pkg::*;
#(
  parameter int          BASE       = 0,
  parameter int          SR_AWIDTH  = 8,
  parameter int          TBL_AWIDTH = 9,
  parameter int          LEN_SHIFT  = 2,
  parameter logic [7:0]  IP_TTL     = 8'h10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  input  logic [63:0]          in_tdata,
  input  logic [15:0]          in_tuser,
  input  logic                 in_tlast,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  output logic [63:0]          out_tdata,
  output logic [3:0]           out_tuser,
  output logic                 out_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [31:0]          cnt_sent,
  output logic [31:0]          cnt_drop
);

  localparam int DEPTH = 1 << TBL_AWIDTH;

  state_t                  state, state_nxt;
  logic [1:0]              lk_cnt;
  logic [TBL_AWIDTH-1:0]   sid_q;
  logic [15:0]             len_q;
  logic [47:0]             src_mac;
  logic [31:0]             src_ip;
  logic [15:0]             src_udp;
  logic [TBL_AWIDTH-1:0]   tbl_idx;
  logic [31:0]             tbl_dst_ip      [DEPTH];
  logic [31:0]             tbl_dst_udp_mac [DEPTH];
  logic [31:0]             tbl_dst_mac_lo  [DEPTH];
  logic [DEPTH-1:0]        tbl_en;
  logic [31:0]             rd_dst_ip, rd_dst_udp_mac, rd_dst_mac_lo;
  logic                    rd_en_bit;
  logic                    rd_stb;
  logic [15:0]             bytes, ip_len, udp_len, ident, csum;
  logic                    sent_evt, drop_evt, hdr6_xfer;
  logic                    sid_hi_unused;

  assign sid_hi_unused = ^in_tuser[15:TBL_AWIDTH];
  assign bytes   = len_q << LEN_SHIFT;
  assign ip_len  = bytes + IP_UDP_HDR_LEN;
  assign udp_len = bytes + UDP_HDR_LEN;
  assign rd_stb  = (state == ST_LOOKUP) && (lk_cnt == 2'd0);

  // Global settings; only reset touches them, clear leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_mac <= '0;
      src_ip  <= '0;
      src_udp <= '0;
      tbl_idx <= '0;
    end else if (set_stb) begin
      case (set_addr)
        SR_AWIDTH'(BASE + SR_SRC_MAC_HI): src_mac[47:32] <= set_data[15:0];
        SR_AWIDTH'(BASE + SR_SRC_MAC_LO): src_mac[31:0]  <= set_data;
        SR_AWIDTH'(BASE + SR_SRC_IP):     src_ip         <= set_data;
        SR_AWIDTH'(BASE + SR_SRC_UDP):    src_udp        <= set_data[15:0];
        SR_AWIDTH'(BASE + SR_TBL_IDX):    tbl_idx        <= set_data[TBL_AWIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Destination table RAM: settings writes plus one registered lookup read.
  // Read and write share the edge, so a same-entry collision returns old data.
  always_ff @(posedge clk) begin
    // NOTE: table RAMs are deliberately not reset so they map onto block RAM; only the enable bits are.
    if (set_stb && set_addr == SR_AWIDTH'(BASE + SR_DST_IP))      tbl_dst_ip[tbl_idx]      <= set_data;
    if (set_stb && set_addr == SR_AWIDTH'(BASE + SR_DST_UDP_MAC)) tbl_dst_udp_mac[tbl_idx] <= set_data;
    if (set_stb && set_addr == SR_AWIDTH'(BASE + SR_DST_MAC_LO))  tbl_dst_mac_lo[tbl_idx]  <= set_data;
    if (rd_stb) begin
      rd_dst_ip      <= tbl_dst_ip[sid_q];
      rd_dst_udp_mac <= tbl_dst_udp_mac[sid_q];
      rd_dst_mac_lo  <= tbl_dst_mac_lo[sid_q];
    end
  end

  // Entry enable bits and their lookup copy; cleared by reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_en    <= '0;
      rd_en_bit <= 1'b0;
    end else begin
      if (set_stb && set_addr == SR_AWIDTH'(BASE + SR_ENTRY_EN)) tbl_en[tbl_idx] <= set_data[0];
      if (rd_stb) rd_en_bit <= tbl_en[sid_q];
    end
  end

  // Capture stream ID and length from beat 0 while it waits in IDLE.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_tvalid) begin
      sid_q <= in_tuser[TBL_AWIDTH-1:0];
      len_q <= in_tdata[15:0];
    end
  end

`ifdef VRLP_FRAMER_IDENT_EN
  // IPv4 identification advances once per emitted header block.
  always_ff @(posedge clk) begin
    if (reset || clear) ident <= '0;
    else if (hdr6_xfer) ident <= ident + 16'd1;
  end
`else
  logic hdr6_unused;
  assign hdr6_unused = hdr6_xfer;
  assign ident       = 16'h0;
`endif

  ip_hdr_checksum_pipe u_csum (
    .clk  (clk),
    .hdr  ({IP_VER_IHL_TOS, ip_len, ident, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP,
            16'h0, src_ip, rd_dst_ip}),
    .csum (csum)
  );

  // State register, lookup timer and packet counters.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= ST_IDLE;
      lk_cnt   <= '0;
      cnt_sent <= '0;
      cnt_drop <= '0;
    end else begin
      state    <= state_nxt;
      lk_cnt   <= (state == ST_LOOKUP) ? lk_cnt + 2'd1 : 2'd0;
      if (sent_evt) cnt_sent <= cnt_sent + 32'd1;
      if (drop_evt) cnt_drop <= cnt_drop + 32'd1;
    end
  end

  // Next state, header beat mux and payload pass-through.
  always_comb begin
    state_nxt  = state;
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    out_tuser  = '0;
    sent_evt   = 1'b0;
    drop_evt   = 1'b0;
    hdr6_xfer  = 1'b0;
    case (state)
      ST_IDLE: if (in_tvalid) state_nxt = ST_LOOKUP;
      ST_LOOKUP:
        if (lk_cnt == 2'(LOOKUP_CYCLES - 1)) state_nxt = rd_en_bit ? ST_HDR1 : ST_DROP;
      ST_HDR1: begin
        out_tvalid = 1'b1;
        out_tdata  = {48'h0, rd_dst_udp_mac[15:0]};
        if (out_tready) state_nxt = ST_HDR2;
      end
      ST_HDR2: begin
        out_tvalid = 1'b1;
        out_tdata  = {rd_dst_mac_lo, src_mac[47:16]};
        if (out_tready) state_nxt = ST_HDR3;
      end
      ST_HDR3: begin
        out_tvalid = 1'b1;
        out_tdata  = {src_mac[15:0], ETH_TYPE_IPV4, IP_VER_IHL_TOS, ip_len};
        if (out_tready) state_nxt = ST_HDR4;
      end
      ST_HDR4: begin
        out_tvalid = 1'b1;
        out_tdata  = {ident, IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP, csum};
        if (out_tready) state_nxt = ST_HDR5;
      end
      ST_HDR5: begin
        out_tvalid = 1'b1;
        out_tdata  = {src_ip, rd_dst_ip};
        if (out_tready) state_nxt = ST_HDR6;
      end
      ST_HDR6: begin
        out_tvalid = 1'b1;
        out_tdata  = {src_udp, rd_dst_udp_mac[31:16], udp_len, 16'h0};
        hdr6_xfer  = out_tready;
        if (out_tready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        in_tready  = out_tready;
        out_tvalid = in_tvalid;
        out_tdata  = in_tdata;
        out_tlast  = in_tlast;
        out_tuser  = in_tlast ? {1'b0, bytes[2:0]} : 4'h0;
        if (in_tvalid && out_tready && in_tlast) begin
          sent_evt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_tlast) begin
          drop_evt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vrlp_eth_framer_tbl.sv
// Self-checking bench for vrlp_eth_framer_tbl with directed vectors and
// hand-computed header beats; honours VRLP_FRAMER_IDENT_EN for ident.
module tb_vrlp_eth_framer_tbl;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] in_tdata;
  logic [15:0] in_tuser;
  logic        in_tlast, in_tvalid, in_tready;
  logic [63:0] out_tdata;
  logic [3:0]  out_tuser;
  logic        out_tlast, out_tvalid, out_tready;
  logic [31:0] cnt_sent, cnt_drop;
  logic        bp_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  beat_t cap_q[$];
  beat_t exp_q[$];

  // Reference model state.
  logic [47:0] m_src_mac;
  logic [31:0] m_src_ip;
  logic [15:0] m_src_udp;
  logic [31:0] m_dst_ip  [16];
  logic [15:0] m_dst_udp [16];
  logic [47:0] m_dst_mac [16];
  int          ident_m = 0;
  int          sent_m  = 0;
  int          drop_m  = 0;

  vrlp_eth_framer_tbl dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .cnt_sent(cnt_sent), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  // Output ready: 30% random stalls while backpressure is enabled.
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Output monitor: records each beat that will transfer on the next edge.
  always @(negedge clk) begin
    if (!reset && out_tvalid && out_tready)
      cap_q.push_back('{data: out_tdata, user: out_tuser, last: out_tlast});
  end

  function automatic logic [63:0] beat_data(input logic [15:0] tag, input int i,
                                            input logic [15:0] len);
    logic [15:0] lo;
    lo = (i == 0) ? len : 16'(i * 3 + 1);
    return {tag, 16'(i), 16'hC0DE, lo};
  endfunction

  task automatic wr(input int addr, input logic [31:0] data);
    set_stb = 1'b1; set_addr = 8'(addr); set_data = data;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic program_src();
    m_src_mac = 48'h0A0B0C0D0E0F; m_src_ip = 32'h0A000001; m_src_udp = 16'h1234;
    wr(0, 32'h0000_0A0B);
    wr(1, 32'h0C0D_0E0F);
    wr(2, m_src_ip);
    wr(3, {16'h0, m_src_udp});
  endtask

  task automatic program_entry(input int idx, input logic [31:0] ip, input logic [15:0] udp,
                               input logic [47:0] mac, input logic en);
    m_dst_ip[idx] = ip; m_dst_udp[idx] = udp; m_dst_mac[idx] = mac;
    wr(4, 32'(idx));
    wr(5, ip);
    wr(6, {udp, mac[47:32]});
    wr(7, mac[31:0]);
    wr(8, {31'h0, en});
  endtask

  task automatic program_all();
    program_src();
    program_entry(5, 32'h0A000002, 16'hC001, 48'h001122334455, 1'b1);
    program_entry(7, 32'h0A000007, 16'h0007, 48'h000000000007, 1'b0);
    program_entry(9, 32'hC0A80164, 16'h0050, 48'hAABBCCDDEEFF, 1'b1);
  endtask

  // Expected framed packet: six header beats then the payload as sent.
  task automatic push_expected(input int sid, input logic [15:0] len, input int nbeats,
                               input logic [15:0] tag);
    logic [15:0] bytes, ip_len, udp_len, id, csum;
    logic [31:0] s;
    bytes   = len << 2;
    ip_len  = bytes + 16'd28;
    udp_len = bytes + 16'd8;
    id      = 16'(ident_m);
    s = 32'h4500 + 32'(ip_len) + 32'(id) + 32'h4000 + 32'h1011
      + 32'(m_src_ip[31:16]) + 32'(m_src_ip[15:0])
      + 32'(m_dst_ip[sid][31:16]) + 32'(m_dst_ip[sid][15:0]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    csum = ~s[15:0];
    exp_q.push_back('{{48'h0, m_dst_mac[sid][47:32]}, 4'h0, 1'b0});
    exp_q.push_back('{{m_dst_mac[sid][31:0], m_src_mac[47:16]}, 4'h0, 1'b0});
    exp_q.push_back('{{m_src_mac[15:0], 16'h0800, 16'h4500, ip_len}, 4'h0, 1'b0});
    exp_q.push_back('{{id, 16'h4000, 8'h10, 8'h11, csum}, 4'h0, 1'b0});
    exp_q.push_back('{{m_src_ip, m_dst_ip[sid]}, 4'h0, 1'b0});
    exp_q.push_back('{{m_src_udp, m_dst_udp[sid], udp_len, 16'h0}, 4'h0, 1'b0});
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back('{beat_data(tag, i, len),
                        (i == nbeats - 1) ? {1'b0, bytes[2:0]} : 4'h0, i == nbeats - 1});
`ifdef VRLP_FRAMER_IDENT_EN
    ident_m++;
`endif
    sent_m++;
  endtask

  // Drives one packet; stalls counts cycles beats 1..n waited on in_tready.
  task automatic send_pkt(input int sid, input logic [15:0] len, input int nbeats,
                          input logic [15:0] tag, output int stalls);
    int guard;
    stalls = 0;
    for (int i = 0; i < nbeats; i++) begin
      in_tvalid = 1'b1; in_tuser = 16'(sid); in_tlast = (i == nbeats - 1);
      in_tdata  = beat_data(tag, i, len);
      guard = 0;
      forever begin
        @(negedge clk);
        if (in_tready) break;
        if (i > 0) stalls++;
        guard++;
        if (guard > 500) break;
      end
      if (guard > 500) begin
        checks++; failures++;
        $display("FAIL send_timeout sid=%0d beat=%0d: in_tready never rose within 500 cycles", sid, i);
        in_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 3000; c++) begin
      if (cap_q.size() >= n) break;
      @(negedge clk);
    end
    if (cap_q.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_beats: got %0d beats, required %0d", cap_q.size(), n);
    end
  endtask

  // Scoreboard drain: compares every captured beat with the model, then empties both queues.
  task automatic check_stream(input string name);
    int n;
    wait_beats(exp_q.size());
    repeat (4) @(negedge clk);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
    end
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat%0d: got data=%h user=%h last=%b required data=%h user=%h last=%b",
                 name, i, cap_q[i].data, cap_q[i].user, cap_q[i].last,
                 exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    cap_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_tdata = '0; in_tuser = '0; in_tlast = 1'b0; in_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_tvalid, in_tready, out_tlast, out_tuser, cnt_sent, cnt_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b ready=%b last=%b user=%h sent=%0d drop=%0d required all 0",
               out_tvalid, in_tready, out_tlast, out_tuser, cnt_sent, cnt_drop);
    end
    in_tvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_tvalid, in_tready, cnt_sent, cnt_drop} !== '0) begin
      failures++;
      $display("FAIL reset_release: got valid=%b ready=%b sent=%0d drop=%0d required all 0",
               out_tvalid, in_tready, cnt_sent, cnt_drop);
    end
  endtask

  task automatic test_basic();
    logic [63:0] hdr_exp [6];
    int st;
    hdr_exp[0] = {48'h0, 16'h0011};
    hdr_exp[1] = {32'h22334455, 32'h0A0B0C0D};
    hdr_exp[2] = {16'h0E0F, 16'h0800, 16'h4500, 16'h002C};
    hdr_exp[3] = {16'h0000, 16'h4000, 8'h10, 8'h11, 16'h56BF};
    hdr_exp[4] = {32'h0A000001, 32'h0A000002};
    hdr_exp[5] = {16'h1234, 16'hC001, 16'h0018, 16'h0000};
    push_expected(5, 16'd4, 2, 16'h0001);
    send_pkt(5, 16'd4, 2, 16'h0001, st);
    wait_beats(8);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cap_q.size() > k && cap_q[k].data !== hdr_exp[k]) begin
        failures++;
        $display("FAIL basic_hdr%0d: got %h required %h", k + 1, cap_q[k].data, hdr_exp[k]);
      end
    end
    checks++;
    if (cap_q.size() < 8 || cap_q[7].user !== 4'h0 || cap_q[7].last !== 1'b1) begin
      failures++;
      $display("FAIL basic_last_beat: beats=%0d, required user=0 last=1 on beat 8", cap_q.size());
    end
    check_stream("basic");
    checks++;
    if (cnt_sent !== 32'd1) begin
      failures++;
      $display("FAIL basic_cnt_sent: got %0d required 1", cnt_sent);
    end
  endtask

  task automatic test_len_boundaries();
    logic [15:0] lens   [4] = '{16'd3, 16'd0, 16'h3FFF, 16'h4000};
    int          nbs    [4] = '{2, 1, 1, 1};
    logic [15:0] iplens [4] = '{16'h0028, 16'h001C, 16'h0018, 16'h001C};
    logic [15:0] udplens[4] = '{16'h0014, 16'h0008, 16'h0004, 16'h0008};
    logic [3:0]  users  [4] = '{4'h4, 4'h0, 4'h4, 4'h0};
    int st;
    for (int c = 0; c < 4; c++) begin
      push_expected(5, lens[c], nbs[c], 16'(16'h0010 + c));
      send_pkt(5, lens[c], nbs[c], 16'(16'h0010 + c), st);
      wait_beats(6 + nbs[c]);
      checks++;
      if (cap_q.size() < 6 + nbs[c] || cap_q[2].data[15:0] !== iplens[c] ||
          cap_q[5].data[31:16] !== udplens[c] || cap_q[5 + nbs[c]].user !== users[c]) begin
        failures++;
        $display("FAIL len_case%0d: got ip_len=%h udp_len=%h user=%h required %h %h %h", c,
                 cap_q[2].data[15:0], cap_q[5].data[31:16], cap_q[5 + nbs[c]].user,
                 iplens[c], udplens[c], users[c]);
      end
      check_stream("len");
    end
  endtask

  task automatic test_drop();
    int st;
    send_pkt(7, 16'd10, 5, 16'h0070, st);
    drop_m++;
    checks++;
    if (st !== 0) begin
      failures++;
      $display("FAIL drop_ready: got %0d stall cycles required 0", st);
    end
    @(negedge clk);
    checks++;
    if (cnt_drop !== 32'(drop_m)) begin
      failures++;
      $display("FAIL drop_cnt: got %0d required %0d", cnt_drop, drop_m);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (cap_q.size() != 0) begin
      failures++;
      $display("FAIL drop_no_output: got %0d beats required 0", cap_q.size());
    end
    cap_q.delete();
    push_expected(5, 16'd6, 3, 16'h0071);
    send_pkt(5, 16'd6, 3, 16'h0071, st);
    check_stream("after_drop");
    checks++;
    if (cnt_sent !== 32'(sent_m)) begin
      failures++;
      $display("FAIL after_drop_cnt_sent: got %0d required %0d", cnt_sent, sent_m);
    end
  endtask

  task automatic test_backpressure();
    int st, sid, nb;
    logic [15:0] len;
    bp_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      sid = (p % 3 == 0) ? 9 : 5;
      len = 16'($urandom_range(0, 10));
      nb  = (len == 0) ? 1 : (int'(len) * 4 + 7) / 8;
      push_expected(sid, len, nb, 16'(16'h0100 + p));
      send_pkt(sid, len, nb, 16'(16'h0100 + p), st);
    end
    check_stream("backpressure");
    bp_en = 1'b0;
    checks++;
    if (cnt_sent !== 32'(sent_m)) begin
      failures++;
      $display("FAIL bp_cnt_sent: got %0d required %0d", cnt_sent, sent_m);
    end
  endtask

  task automatic test_reset_clear();
    int st, guard;
    // Reset while HDR3 is on the bus.
    in_tvalid = 1'b1; in_tuser = 16'd5; in_tlast = 1'b0; in_tdata = beat_data(16'h0200, 0, 16'd4);
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (!(out_tvalid && out_tdata[47:16] == 32'h0800_4500) && guard < 200);
    reset = 1'b1; in_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (guard >= 200 || {out_tvalid, in_tready, out_tlast, out_tuser, cnt_sent, cnt_drop} !== '0) begin
      failures++;
      $display("FAIL reset_mid_hdr3: guard=%0d valid=%b ready=%b sent=%0d drop=%0d required 0",
               guard, out_tvalid, in_tready, cnt_sent, cnt_drop);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sent_m = 0; drop_m = 0; ident_m = 0;
    cap_q.delete(); exp_q.delete();
    program_all();
    push_expected(5, 16'd4, 2, 16'h0201);
    send_pkt(5, 16'd4, 2, 16'h0201, st);
    check_stream("post_reset");
    // Clear while the first payload beat is presented.
    in_tvalid = 1'b1; in_tuser = 16'd5; in_tlast = 1'b0; in_tdata = beat_data(16'h0202, 0, 16'd6);
    guard = 0;
    do begin @(negedge clk); guard++; end
    while (!(out_tvalid && out_tdata == beat_data(16'h0202, 0, 16'd6)) && guard < 200);
    clear = 1'b1; in_tvalid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (guard >= 200 || {out_tvalid, in_tready, out_tlast, out_tuser, cnt_sent, cnt_drop} !== '0) begin
      failures++;
      $display("FAIL clear_mid_payload: guard=%0d valid=%b ready=%b sent=%0d drop=%0d required 0",
               guard, out_tvalid, in_tready, cnt_sent, cnt_drop);
    end
    sent_m = 0; drop_m = 0; ident_m = 0;
    cap_q.delete(); exp_q.delete();
    push_expected(5, 16'd5, 3, 16'h0203);
    send_pkt(5, 16'd5, 3, 16'h0203, st);
    check_stream("post_clear");
    checks++;
    if (cnt_sent !== 32'd1) begin
      failures++;
      $display("FAIL post_clear_cnt_sent: got %0d required 1", cnt_sent);
    end
  endtask

  task automatic test_ident();
    int st;
    logic [15:0] exp_id;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sent_m = 0; drop_m = 0; ident_m = 0;
    for (int k = 0; k < 3; k++) begin
`ifdef VRLP_FRAMER_IDENT_EN
      exp_id = 16'(k);
`else
      exp_id = 16'h0;
`endif
      push_expected(5, 16'd2, 1, 16'(16'h0300 + k));
      send_pkt(5, 16'd2, 1, 16'(16'h0300 + k), st);
      wait_beats(7);
      checks++;
      if (cap_q.size() < 4 || cap_q[3].data[63:48] !== exp_id) begin
        failures++;
        $display("FAIL ident_pkt%0d: got %h required %h", k, cap_q[3].data[63:48], exp_id);
      end
      check_stream("ident");
    end
  endtask

  initial begin
    test_reset();
    program_all();
    test_basic();
    test_len_boundaries();
    test_drop();
    test_backpressure();
    test_reset_clear();
    test_ident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
